nibble_entry: RTL and testbench
===============================

# nibble_entry

Front-end input stage for the switch-driven 4-bit divisibility/parity LED decoder. It turns one data switch and a step pushbutton into a 4-bit value, one bit per press, MSB first. The assembled nibble drives the decoder's `In[3:0]` directly. Both buttons are synchronized and debounced, and the presented nibble is held stable between completed entries so the LEDs never show a partially entered value.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive cycles a synchronized button level must differ from its debounced level before the debounced level flips (10 ms at 100 MHz). Legal range 2..2^24-1.
- `clk` input 1: system clock; all state is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset; deassertion is synchronous to `clk` at the board level.
- `btn_step` input 1: raw step pushbutton, active-high, asynchronous.
- `btn_clear` input 1: raw clear pushbutton, active-high, asynchronous.
- `sw_bit` input 1: raw data switch, asynchronous; its level is the bit captured on each step.
- `nibble` output 4: last completed 4-bit value, MSB = first bit entered; feeds decoder `In`.
- `nibble_valid` output 1: high once a full nibble has been entered since reset or clear.
- `done` output 1: one-cycle pulse on the cycle `nibble` updates.
- `bits_entered` output 3: bits captured in the entry in progress, 0..3.
- `partial` output 4: in-progress shift register, for optional display.

## Operation
- **Synchronizers:** `btn_step`, `btn_clear` and `sw_bit` each pass through a 2-flop synchronizer. All internal logic uses the synchronized copies only.
- **Debounce (per button, independent):**
  - Each button keeps a debounced level and a counter.
  - If the synchronized level equals the debounced level, the counter is cleared to 0.
  - Otherwise the counter increments. When it would reach `DEBOUNCE_CYCLES`, the debounced level takes the synchronized level and the counter clears.
  - Any bounce back to the debounced level restarts the count.
  - `sw_bit` is not debounced. Its synchronized level is sampled only on a step.
- **Edges:** `step_p` and `clear_p` are one-cycle internal strobes on each 0→1 transition of their debounced level. Releases generate nothing.
- **Entry datapath:**
  - On `step_p` with `bits_entered` < 3: `partial <= {partial[2:0], sw_bit_s}` and `bits_entered` increments.
  - On `step_p` with `bits_entered` == 3: `nibble <= {partial[2:0], sw_bit_s}`, `nibble_valid <= 1`, `done <= 1`, `partial <= 0`, `bits_entered <= 0`.
  - `nibble` otherwise holds its value. A new entry never disturbs `nibble` until its 4th bit.
- **Clear:** on `clear_p`, `partial`, `bits_entered`, `nibble` and `nibble_valid` all go to 0, and `done` stays 0.
- **Simultaneous `step_p` and `clear_p`:** clear wins and the step is discarded.
- **Reset values:** `nibble` = 0, `nibble_valid` = 0, `done` = 0, `bits_entered` = 0, `partial` = 0. All synchronizer flops, debounced levels and counters reset to 0, so a button held through reset release debounces as a fresh press.
- **Reset mid-entry:** discards the partial entry and the held nibble with no residual pulse.

## Timing
- **Press latency:** a clean press arriving at cycle 0 reaches the synchronized level at cycle 2.
  - The debounced level rises at cycle 2+`DEBOUNCE_CYCLES`.
  - `step_p` is high at cycle 3+`DEBOUNCE_CYCLES`.
  - `partial`, `bits_entered`, `nibble` and `done` update on the following edge, so they are visible at cycle 4+`DEBOUNCE_CYCLES`.
- **`done`:** exactly one cycle wide; it coincides with the first cycle `nibble` shows the new value.
- **Press rate:** one press yields one step regardless of hold duration. There is no auto-repeat.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles produces no strobe.
- **Outputs:** all outputs are registered, with no combinational paths from inputs to outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset:** assert `rst_n`=0 asynchronously mid-cycle → all outputs 0 immediately; after release with buttons idle, outputs stay 0 for 100 cycles.
- **Basic entry:** enter bits 1,0,0,1 with clean presses, each held 20 cycles → `bits_entered` steps 1,2,3,0; `partial` shows 0001, 0010, 0100; `nibble`=4'b1001, `nibble_valid`=1, `done` a single-cycle pulse at press latency 8 cycles after the 4th press edge.
- **Bounce rejection:** precede each press with 3-cycle high / 1-cycle low chatter, then a stable hold; add 3-cycle glitches → exactly one step per press; entering 0,1,1,0 yields `nibble`=4'b0110 and no extra steps.
- **Hold-while-entering:** after `nibble`=1001, enter 1,1 → `nibble` stays 1001 and `bits_entered`=2; complete with 1,1 → `nibble`=1111 with one `done` pulse.
- **Clear and collision:**
  - Mid-entry clear → `partial`=0, `bits_entered`=0, `nibble`=0, `nibble_valid`=0.
  - Press step and clear on the same cycle → clear only, `bits_entered` stays 0.
- **Reset mid-entry:** after 2 bits entered with a prior valid `nibble`=1100, pulse `rst_n` low for 1 cycle → all outputs 0; a held step button produces exactly one step after release.

Source files
------------

// File: rtl/nibble_entry.sv
// Switch + step-button nibble entry: syncs and debounces the buttons, shifts in
// one bit per debounced step press (MSB first), presents the completed nibble.

module nibble_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_lvl;
  logic          r_lvl_q;
  logic          r_rise;

  // Any return to the debounced level restarts the qualification count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_lvl_q <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      if (i_lvl == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_lvl <= i_lvl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_lvl_q <= r_lvl;
      r_rise  <= r_lvl & ~r_lvl_q;
    end
  end

  assign o_rise = r_rise;
endmodule

module nibble_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_step,
  input  logic       btn_clear,
  input  logic       sw_bit,
  output logic [3:0] nibble,
  output logic       nibble_valid,
  output logic       done,
  output logic [2:0] bits_entered,
  output logic [3:0] partial
);
  localparam int NUM_BTN = 2;

  // bit 0 = step, bit 1 = clear, bit 2 = data switch (never debounced)
  logic [2:0]         r_sync1;
  logic [2:0]         r_sync2;
  logic [NUM_BTN-1:0] w_rise;
  logic               w_step_p;
  logic               w_clear_p;
  logic               w_sw_s;

  logic [3:0] r_nibble;
  logic       r_valid;
  logic       r_done;
  logic [2:0] r_bits;
  logic [3:0] r_partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {sw_bit, btn_clear, btn_step};
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    nibble_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_lvl  (r_sync2[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_step_p  = w_rise[0];
  assign w_clear_p = w_rise[1];
  assign w_sw_s    = r_sync2[2];

  // Clear has priority; a coincident step is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nibble  <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_bits    <= '0;
      r_partial <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_clear_p) begin
        r_nibble  <= '0;
        r_valid   <= 1'b0;
        r_bits    <= '0;
        r_partial <= '0;
      end else if (w_step_p) begin
        if (r_bits == 3'd3) begin
          r_nibble  <= {r_partial[2:0], w_sw_s};
          r_valid   <= 1'b1;
          r_done    <= 1'b1;
          r_bits    <= '0;
          r_partial <= '0;
        end else begin
          r_partial <= {r_partial[2:0], w_sw_s};
          r_bits    <= r_bits + 3'd1;
        end
      end
    end
  end

  assign nibble       = r_nibble;
  assign nibble_valid = r_valid;
  assign done         = r_done;
  assign bits_entered = r_bits;
  assign partial      = r_partial;
endmodule

// File: tb/tb_nibble_entry.sv
// Scoreboard bench for nibble_entry: completed nibbles are queued when the 4th
// press is driven and checked against each done pulse, including its latency.

module tb_nibble_entry;
  localparam int DB = 4;
  localparam int LAT = 4 + DB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_step = 1'b0;
  logic       btn_clear = 1'b0;
  logic       sw_bit = 1'b0;
  logic [3:0] nibble;
  logic       nibble_valid;
  logic       done;
  logic [2:0] bits_entered;
  logic [3:0] partial;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_press_cyc = 0;
  int n_done = 0;
  logic prev_done = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] m_part = '0;
  int         m_bits = 0;

  nibble_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_step     (btn_step),
    .btn_clear    (btn_clear),
    .sw_bit       (sw_bit),
    .nibble       (nibble),
    .nibble_valid (nibble_valid),
    .done         (done),
    .bits_entered (bits_entered),
    .partial      (partial)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every done pulse pops one expected nibble.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      chk("done_width", {31'd0, prev_done}, 32'd0);
      chk("done_latency", cyc - last_press_cyc, LAT);
      if (exp_q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
      else chk("sb_nibble", {28'd0, nibble}, {28'd0, exp_q.pop_front()});
    end
    prev_done = done;
  end

  task automatic model_step(input logic b);
    if (m_bits == 3) begin
      exp_q.push_back({m_part[2:0], b});
      m_part = '0;
      m_bits = 0;
    end else begin
      m_part = {m_part[2:0], b};
      m_bits++;
    end
  endtask

  task automatic press(input logic b, input bit bounce);
    sw_bit = b;
    tick(3);
    if (bounce) begin
      repeat (2) begin
        btn_step = 1'b1; tick(3);
        btn_step = 1'b0; tick(1);
      end
    end
    btn_step = 1'b1;
    last_press_cyc = cyc;
    model_step(b);
    tick(20);
    btn_step = 1'b0;
    tick(20);
  endtask

  task automatic glitch();
    btn_step = 1'b1; tick(3);
    btn_step = 1'b0; tick(20);
  endtask

  task automatic press_clear(input bit with_step);
    btn_clear = 1'b1;
    if (with_step) btn_step = 1'b1;
    m_part = '0;
    m_bits = 0;
    tick(20);
    btn_clear = 1'b0;
    btn_step  = 1'b0;
    tick(20);
  endtask

  task automatic chk_state(input string tag, input logic [3:0] nib, input logic vld,
                           input logic [2:0] bits, input logic [3:0] part);
    chk({tag, "_nibble"}, {28'd0, nibble}, {28'd0, nib});
    chk({tag, "_valid"}, {31'd0, nibble_valid}, {31'd0, vld});
    chk({tag, "_bits"}, {29'd0, bits_entered}, {29'd0, bits});
    chk({tag, "_partial"}, {28'd0, partial}, {28'd0, part});
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] part_exp [3] = '{4'b0001, 4'b0010, 4'b0100};
    bit idle_ok;

    // Reset asserted mid-cycle must clear outputs immediately.
    tick(3);
    #2 rst_n = 1'b0;
    #1 chk_state("rst_async", 4'h0, 1'b0, 3'd0, 4'h0);
    chk("rst_async_done", {31'd0, done}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (nibble != 0 || nibble_valid || done || bits_entered != 0 || partial != 0) idle_ok = 1'b0;
    end
    chk("rst_idle_100", {31'd0, idle_ok}, 32'd1);

    // Basic entry 1,0,0,1
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      press(pat[3-i], 1'b0);
      if (i < 3) begin
        chk("basic_bits", {29'd0, bits_entered}, i + 1);
        chk("basic_partial", {28'd0, partial}, {28'd0, part_exp[i]});
      end
    end
    chk_state("basic_done", 4'b1001, 1'b1, 3'd0, 4'h0);

    // Partial entry leaves the held nibble untouched
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk_state("hold_mid", 4'b1001, 1'b1, 3'd2, 4'b0011);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk_state("hold_done", 4'b1111, 1'b1, 3'd0, 4'h0);

    // Chattered presses plus short glitches: 0,1,1,0
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      glitch();
      press(pat[3-i], 1'b1);
      if (i < 3) chk("bounce_bits", {29'd0, bits_entered}, i + 1);
    end
    glitch();
    chk_state("bounce_done", 4'b0110, 1'b1, 3'd0, 4'h0);

    // Mid-entry clear
    press(1'b1, 1'b0);
    press(1'b0, 1'b0);
    chk("clr_pre_bits", {29'd0, bits_entered}, 32'd2);
    press_clear(1'b0);
    chk_state("clr_mid", 4'h0, 1'b0, 3'd0, 4'h0);

    // Step and clear together: clear wins
    press(1'b1, 1'b0);
    sw_bit = 1'b1;
    tick(3);
    press_clear(1'b1);
    chk_state("collide", 4'h0, 1'b0, 3'd0, 4'h0);

    // Reset mid-entry with step held through release
    pat = 4'b1100;
    for (int i = 0; i < 4; i++) press(pat[3-i], 1'b0);
    chk_state("pre_rst", 4'b1100, 1'b1, 3'd0, 4'h0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b0);
    chk("pre_rst_bits", {29'd0, bits_entered}, 32'd2);
    sw_bit = 1'b1;
    btn_step = 1'b1;
    tick(30);
    #2 rst_n = 1'b0;
    #1 chk_state("rst_mid", 4'h0, 1'b0, 3'd0, 4'h0);
    m_part = '0;
    m_bits = 0;
    tick(1);
    rst_n = 1'b1;
    tick(40);
    chk_state("rst_held", 4'h0, 1'b0, 3'd1, 4'b0001);
    btn_step = 1'b0;
    tick(20);
    chk("rst_held_bits", {29'd0, bits_entered}, 32'd1);

    chk("done_count", n_done, 32'd4);
    chk("sb_leftover", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
